// File: rtl/pipelined_datapath_fwd_pkg.sv
// Shared definitions for the pipelined datapath: opcodes, ALU op encodings,
// and instruction field slices.
package pipelined_datapath_fwd_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_SLL  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    function automatic logic [5:0] f_opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] inst);
        return inst[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] inst);
        return inst[15:0];
    endfunction

    function automatic alu_op_e f_aluop(input logic [31:0] inst);
        return alu_op_e'(inst[2:0]);
    endfunction

endpackage

// File: rtl/pipelined_datapath_fwd_regfile_wt.sv
// 2-read/1-write register file with write-through reads, r0 hard-wired to
// zero, and a third (debug) read port that shows the stored contents.
module regfile_wt #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr_a,
    input  logic [ASIZE-1:0] raddr_b,
    input  logic [ASIZE-1:0] dbg_raddr,
    output logic [DSIZE-1:0] rdata_a,
    output logic [DSIZE-1:0] rdata_b,
    output logic [DSIZE-1:0] dbg_rdata
);

    localparam int unsigned NREG = 2 ** ASIZE;

    logic [DSIZE-1:0] mem_q [NREG];

    // Storage: cleared on reset, r0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a == '0) ? '0 :
                       (we && raddr_a == waddr) ? wdata : mem_q[raddr_a];
    assign rdata_b   = (raddr_b == '0) ? '0 :
                       (we && raddr_b == waddr) ? wdata : mem_q[raddr_b];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem_q[dbg_raddr];

endmodule

// File: rtl/pipelined_datapath_fwd.sv
// 4-stage IF/ID/EXE/WB integer datapath. A distance-1 dependence is either
// forwarded from EXE_WB into the EXE operands (FWD_EN=1) or resolved with a
// one-cycle interlock (FWD_EN=0); distance-2 is covered by regfile write-through.
module pipelined_datapath_fwd
    import pipelined_datapath_fwd_pkg::*;
#(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 5,
    parameter bit FWD_EN   = 1'b1,
    parameter bit IMM_SEXT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             wb_valid,
    output logic [ASIZE-1:0] wb_addr,
    output logic [DSIZE-1:0] wb_data,
    input  logic [ASIZE-1:0] dbg_raddr,
    output logic [DSIZE-1:0] dbg_rdata,
    output logic [15:0]      stall_cnt
);

    logic             ifid_valid_q, ifid_valid_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;

    logic             idex_valid_q, idex_valid_d;
    logic [ASIZE-1:0] idex_dst_q, idex_dst_d;
    logic [ASIZE-1:0] idex_src_a_q, idex_src_a_d;
    logic [ASIZE-1:0] idex_src_b_q, idex_src_b_d;
    alu_op_e          idex_op_q, idex_op_d;
    logic [DSIZE-1:0] idex_a_q, idex_a_d;
    logic [DSIZE-1:0] idex_b_q, idex_b_d;

    logic             exwb_valid_q, exwb_valid_d;
    logic [ASIZE-1:0] exwb_dst_q, exwb_dst_d;
    logic [DSIZE-1:0] exwb_data_q, exwb_data_d;

    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             is_r, is_i, id_wen, hazard, stall;
    logic [ASIZE-1:0] id_rs, id_rt, id_dst;
    alu_op_e          id_op;
    logic [15:0]      imm16;
    logic [DSIZE-1:0] id_imm, rf_a, rf_b, ex_a, ex_b;
    logic             unused_bits;

    function automatic logic [DSIZE-1:0] alu(input alu_op_e op,
                                             input logic [DSIZE-1:0] a,
                                             input logic [DSIZE-1:0] b);
        logic [DSIZE-1:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  r = a << b[4:0];
            ALU_PASS: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    regfile_wt #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (exwb_valid_q),
        .waddr    (exwb_dst_q),
        .wdata    (exwb_data_q),
        .raddr_a  (id_rs),
        .raddr_b  (id_rt),
        .dbg_raddr(dbg_raddr),
        .rdata_a  (rf_a),
        .rdata_b  (rf_b),
        .dbg_rdata(dbg_rdata)
    );

    // Decode of the IF_ID instruction and distance-1 hazard detection.
    always_comb begin
        is_r   = ifid_valid_q && f_opcode(ifid_instr_q) == OP_RTYPE;
        is_i   = ifid_valid_q && f_opcode(ifid_instr_q) == OP_ADDI;
        id_wen = is_r || is_i;
        id_rs  = ASIZE'(f_rs(ifid_instr_q));
        id_rt  = ASIZE'(f_rt(ifid_instr_q));
        id_dst = is_r ? ASIZE'(f_rd(ifid_instr_q)) : id_rt;
        id_op  = is_r ? f_aluop(ifid_instr_q) : ALU_ADD;
        imm16  = f_imm(ifid_instr_q);
        id_imm = IMM_SEXT ? DSIZE'($signed(imm16)) : DSIZE'(imm16);
        hazard = idex_valid_q && idex_dst_q != '0 &&
                 ((id_wen && id_rs == idex_dst_q) || (is_r && id_rt == idex_dst_q));
        stall  = !FWD_EN && hazard;
    end

    // Next-state for all stage registers; non-writing slots carry an all-zero record.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        if (!stall) begin
            ifid_valid_d = instr_valid;
            ifid_instr_d = instr_valid ? instr_in : '0;
        end

        idex_valid_d = 1'b0;
        idex_dst_d   = '0;
        idex_src_a_d = '0;
        idex_src_b_d = '0;
        idex_op_d    = ALU_ADD;
        idex_a_d     = '0;
        idex_b_d     = '0;
        if (id_wen && !stall) begin
            idex_valid_d = 1'b1;
            idex_dst_d   = id_dst;
            idex_src_a_d = id_rs;
            idex_src_b_d = is_r ? id_rt : '0;
            idex_op_d    = id_op;
            idex_a_d     = rf_a;
            idex_b_d     = is_r ? rf_b : id_imm;
        end

        // Operands read in ID are stale for the instruction now in EXE_WB.
        ex_a = (FWD_EN && exwb_valid_q && exwb_dst_q != '0 && exwb_dst_q == idex_src_a_q)
               ? exwb_data_q : idex_a_q;
        ex_b = (FWD_EN && exwb_valid_q && exwb_dst_q != '0 && exwb_dst_q == idex_src_b_q)
               ? exwb_data_q : idex_b_q;

        exwb_valid_d = idex_valid_q;
        exwb_dst_d   = idex_dst_q;
        exwb_data_d  = alu(idex_op_q, ex_a, ex_b);

        stall_cnt_d  = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // Pipeline and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            idex_valid_q <= 1'b0;
            idex_dst_q   <= '0;
            idex_src_a_q <= '0;
            idex_src_b_q <= '0;
            idex_op_q    <= ALU_ADD;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            exwb_valid_q <= 1'b0;
            exwb_dst_q   <= '0;
            exwb_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            idex_valid_q <= idex_valid_d;
            idex_dst_q   <= idex_dst_d;
            idex_src_a_q <= idex_src_a_d;
            idex_src_b_q <= idex_src_b_d;
            idex_op_q    <= idex_op_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            exwb_valid_q <= exwb_valid_d;
            exwb_dst_q   <= exwb_dst_d;
            exwb_data_q  <= exwb_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign instr_ready = !stall;
    assign wb_valid    = exwb_valid_q;
    assign wb_addr     = exwb_dst_q;
    assign wb_data     = exwb_data_q;
    assign stall_cnt   = stall_cnt_q;
    assign unused_bits = ^ifid_instr_q[10:3];

endmodule

// File: tb/tb_pipelined_datapath_fwd.sv
// Bench for pipelined_datapath_fwd: a forwarding instance and an interlock
// instance run the same instruction streams; write-backs are compared in
// order against expected values from a table or an architectural model.
`timescale 1ns/1ps
module tb_pipelined_datapath_fwd;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed { logic v; logic [31:0] ins; } slot_t;
    typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
    typedef struct { logic v; logic [31:0] ins; logic ew; logic [4:0] ea; logic [31:0] ed; } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr_in    [2];
    logic          instr_valid [2];
    logic          instr_ready [2];
    logic          wb_valid    [2];
    logic [AW-1:0] wb_addr     [2];
    logic [DW-1:0] wb_data     [2];
    logic [AW-1:0] dbg_raddr = '0;
    logic [DW-1:0] dbg_rdata   [2];
    logic [15:0]   stall_cnt   [2];

    int    total = 0;
    int    bad   = 0;
    logic  mon_en = 1'b0;
    int    widx    [2];
    int    rdy_low [2];
    slot_t prog [$];
    wb_t   expq [$];
    vec_t  tbl  [$];
    logic [31:0] m_rf [32];

    always #5 clk = ~clk;

    pipelined_datapath_fwd #(.DSIZE(DW), .ASIZE(AW), .FWD_EN(1'b1), .IMM_SEXT(1'b0)) u_fwd (
        .clk(clk), .rst(rst), .instr_in(instr_in[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .wb_valid(wb_valid[0]), .wb_addr(wb_addr[0]),
        .wb_data(wb_data[0]), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata[0]),
        .stall_cnt(stall_cnt[0]));

    pipelined_datapath_fwd #(.DSIZE(DW), .ASIZE(AW), .FWD_EN(1'b0), .IMM_SEXT(1'b0)) u_stl (
        .clk(clk), .rst(rst), .instr_in(instr_in[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .wb_valid(wb_valid[1]), .wb_addr(wb_addr[1]),
        .wb_data(wb_data[1]), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata[1]),
        .stall_cnt(stall_cnt[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int dst, input int rs, input int imm);
        return {6'h08, 5'(rs), 5'(dst), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int op);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 8'h00, 3'(op)};
    endfunction

    localparam logic [31:0] NOP = 32'hFC00_0000;

    // Architectural execution of one instruction in program order.
    task automatic model_exec(input logic [31:0] ins, input bit push);
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [2:0]  f;
        logic [31:0] a, b, res;
        op = ins[31:26];
        a  = m_rf[ins[25:21]];
        if (op == 6'h00) begin
            b = m_rf[ins[20:16]]; f = ins[2:0]; dst = ins[15:11];
        end else if (op == 6'h08) begin
            b = {16'h0000, ins[15:0]}; f = 3'd0; dst = ins[20:16];
        end else begin
            return;
        end
        case (f)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: res = a << b[4:0];
            default: res = b;
        endcase
        if (dst != 5'd0) m_rf[dst] = res;
        if (push) expq.push_back('{dst, res});
    endtask

    // Interlock count: each slot that reads the register written by the slot just before it.
    function automatic int exp_stalls();
        int n = 0;
        logic pw = 1'b0;
        logic [4:0] pd = '0;
        foreach (prog[i]) begin
            logic isr, isi;
            logic [4:0] rs, rt;
            isr = prog[i].v && prog[i].ins[31:26] == 6'h00;
            isi = prog[i].v && prog[i].ins[31:26] == 6'h08;
            rs  = prog[i].ins[25:21];
            rt  = prog[i].ins[20:16];
            if (pw && pd != 5'd0 && (((isr || isi) && rs == pd) || (isr && rt == pd))) n++;
            pw = isr || isi;
            pd = isr ? prog[i].ins[15:11] : rt;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (!instr_ready[d]) rdy_low[d]++;
                if (wb_valid[d] === 1'b1) begin
                    if (widx[d] < expq.size()) begin
                        check($sformatf("d%0d_wb_addr_%0d", d, widx[d]), 32'(wb_addr[d]), 32'(expq[widx[d]].a));
                        check($sformatf("d%0d_wb_data_%0d", d, widx[d]), wb_data[d], expq[widx[d]].d);
                    end else begin
                        check($sformatf("d%0d_wb_extra", d), 32'(wb_valid[d]), 32'd0);
                    end
                    widx[d]++;
                end else begin
                    check($sformatf("d%0d_bubble_addr", d), 32'(wb_addr[d]), 32'd0);
                    check($sformatf("d%0d_bubble_data", d), wb_data[d], 32'd0);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin instr_valid[d] = 1'b0; instr_in[d] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        prog.delete();
        expq.delete();
        widx[0] = 0; widx[1] = 0;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            for (int d = 0; d < 2; d++)
                check($sformatf("%s_d%0d_r%0d", tag, d, r), dbg_rdata[d], m_rf[r]);
        end
        dbg_raddr = '0;
    endtask

    task automatic load_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            prog.push_back('{tbl[i].v, tbl[i].ins});
            if (tbl[i].v) model_exec(tbl[i].ins, 1'b0);
            if (tbl[i].ew) expq.push_back('{tbl[i].ea, tbl[i].ed});
        end
    endtask

    task automatic run_prog(input string tag, input int exp_stl);
        int   ptr [2];
        logic adv [2];
        int   cyc = 0;
        int   n   = prog.size();
        ptr[0] = 0; ptr[1] = 0;
        widx[0] = 0; widx[1] = 0;
        rdy_low[0] = 0; rdy_low[1] = 0;
        mon_en = 1'b1;
        while ((ptr[0] < n || ptr[1] < n) && cyc < 4 * n + 20) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                instr_valid[d] = (ptr[d] < n) ? prog[ptr[d]].v : 1'b0;
                instr_in[d]    = (ptr[d] < n) ? prog[ptr[d]].ins : '0;
            end
            #1;
            for (int d = 0; d < 2; d++) adv[d] = (ptr[d] < n) && instr_ready[d];
            @(posedge clk);
            for (int d = 0; d < 2; d++) if (adv[d]) ptr[d]++;
            cyc++;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin instr_valid[d] = 1'b0; instr_in[d] = '0; end
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_consumed", tag, d), 32'(ptr[d]), 32'(n));
            check($sformatf("%s_d%0d_wb_count", tag, d), 32'(widx[d]), 32'(expq.size()));
        end
        check({tag, "_fwd_stall_cnt"}, 32'(stall_cnt[0]), 32'd0);
        check({tag, "_fwd_ready_low"}, 32'(rdy_low[0]), 32'd0);
        check({tag, "_stl_stall_cnt"}, 32'(stall_cnt[1]), 32'(exp_stl));
        check({tag, "_stl_ready_low"}, 32'(rdy_low[1]), 32'(exp_stl));
        mon_en = 1'b0;
        check_regs(tag);
    endtask

    task automatic add(input logic v, input logic [31:0] ins, input logic ew,
                       input int ea, input logic [31:0] ed);
        tbl.push_back('{v, ins, ew, 5'(ea), ed});
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin instr_valid[d] = 1'b0; instr_in[d] = '0; end

        add(1, enc_i(1, 0, 5),        1, 1, 32'd5);
        add(1, enc_i(2, 0, 7),        1, 2, 32'd7);
        add(1, NOP,                   0, 0, 0);
        add(1, NOP,                   0, 0, 0);
        add(1, NOP,                   0, 0, 0);
        add(1, enc_r(3, 1, 2, 0),     1, 3, 32'd12);
        add(1, enc_r(4, 3, 1, 1),     1, 4, 32'd7);
        add(1, NOP,                   0, 0, 0);
        add(0, enc_i(9, 9, 99),       0, 0, 0);
        add(1, NOP,                   0, 0, 0);
        add(1, enc_i(5, 0, 9),        1, 5, 32'd9);
        add(1, NOP,                   0, 0, 0);
        add(1, enc_i(6, 5, 1),        1, 6, 32'd10);
        add(1, NOP,                   0, 0, 0);
        add(1, enc_i(0, 0, 3),        1, 0, 32'd3);
        add(1, enc_i(7, 0, 1),        1, 7, 32'd1);
        add(1, enc_i(9, 0, 16'hFFFF), 1, 9, 32'h0000_FFFF);
        add(1, enc_r(10, 9, 1, 5),    1, 10, 32'd0);
        add(1, enc_r(11, 1, 2, 6),    1, 11, 32'h0000_0280);
        add(1, enc_r(12, 0, 11, 7),   1, 12, 32'h0000_0280);
        add(1, enc_r(13, 12, 12, 2),  1, 13, 32'h0000_0280);
        add(1, enc_r(14, 13, 1, 3),   1, 14, 32'h0000_0285);
        add(1, enc_r(15, 1, 2, 1),    1, 15, 32'hFFFF_FFFE);
        add(1, enc_r(16, 15, 1, 5),   1, 16, 32'd1);
        add(1, enc_r(17, 15, 14, 4),  1, 17, 32'hFFFF_FD7B);
        add(1, enc_r(18, 1, 15, 6),   1, 18, 32'h4000_0000);

        do_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_wb_valid", d), 32'(wb_valid[d]), 32'd0);
            check($sformatf("rst_d%0d_wb_addr", d), 32'(wb_addr[d]), 32'd0);
            check($sformatf("rst_d%0d_wb_data", d), wb_data[d], 32'd0);
            check($sformatf("rst_d%0d_ready", d), 32'(instr_ready[d]), 32'd1);
            check($sformatf("rst_d%0d_stall_cnt", d), 32'(stall_cnt[d]), 32'd0);
        end

        // Basic immediates then a back-to-back dependent ADD/SUB pair.
        load_table(0, 6);
        run_prog("basic", 1);

        // Full table: distance-2, r0 write, every ALU op, rt-only and dual-operand hazards.
        do_reset();
        load_table(0, tbl.size() - 1);
        run_prog("table", 6);

        // Reset with three instructions in flight: none may reach the regfile.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                instr_valid[d] = 1'b1;
                instr_in[d]    = enc_i(20 + k, 0, 32'h100 + k);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("inflight_d%0d_wb_valid", d), 32'(wb_valid[d]), 32'd1);
            check($sformatf("inflight_d%0d_wb_addr", d), 32'(wb_addr[d]), 32'd20);
            instr_valid[d] = 1'b0;
            instr_in[d]    = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        prog.delete();
        expq.delete();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_d%0d_wb_valid", d), 32'(wb_valid[d]), 32'd0);
            check($sformatf("midrst_d%0d_stall_cnt", d), 32'(stall_cnt[d]), 32'd0);
            check($sformatf("midrst_d%0d_ready", d), 32'(instr_ready[d]), 32'd1);
        end
        widx[0] = 0; widx[1] = 0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        check_regs("midrst");

        // Random streams against the architectural model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r;
            slot_t s;
            r = int'($urandom_range(0, 99));
            s.v = 1'b1;
            if (r < 12) begin
                s.v = 1'b0; s.ins = $urandom;
            end else if (r < 55) begin
                s.ins = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end else if (r < 88) begin
                s.ins = enc_i(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 65535)));
            end else begin
                int op;
                op = int'($urandom_range(1, 63));
                if (op == 8) op = 9;
                s.ins = {6'(op), 26'($urandom)};
            end
            prog.push_back(s);
            if (s.v) model_exec(s.ins, 1'b1);
        end
        run_prog("rand", exp_stalls());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
